nonce_dispatcher: RTL and testbench
===================================

NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle job launch; sampled only in IDLE.
REQ-005 abort  input  1  cancel current job.
REQ-006 midstate_in  input  [0:255]  first-block midstate of header.
REQ-007 tail_in  input  [0:95]  header tail: merkle tail, time, bits.
REQ-008 target_in  input  [0:255]  difficulty target, bit 0 = MSB.
REQ-009 nonce_start  input  [31:0]  first nonce to try.
REQ-010 nonce_end  input  [31:0]  last nonce to try, inclusive.
REQ-011 req_valid  output  1  hash request valid to sha256_wrapper side.
REQ-012 req_ready  input  1  hasher accepts request.
REQ-013 midstate  output  [0:255]  midstate for hasher.
REQ-014 block2  output  [0:511]  padded second block for hasher.
REQ-015 rsp_valid  input  1  hash result valid, one cycle.
REQ-016 rsp_hash  input  [0:255]  hash result, bit 0 = MSB.
REQ-017 busy  output  1  job in progress.
REQ-018 done  output  1  one-cycle pulse at job end.
REQ-019 found  output  1  last finished job hit target; held until next start.
REQ-020 found_nonce  output  [31:0]  winning nonce; held until next start.
REQ-021 hash_count  output  [31:0]  responses checked in current or last job.

Function
REQ-022 States SHALL be IDLE, ISSUE, WAIT; encoding free.
REQ-023 IDLE + start=1 + abort=0 SHALL latch midstate_in, tail_in, target_in, nonce_start, nonce_end, clear found/found_nonce/hash_count, set busy, go ISSUE; req_valid high the following cycle.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 block2 SHALL be: [0:95]=latched tail, [96:127]=current nonce, [128]=1, [129:447]=0, [448:511]=64'd640.
REQ-026 midstate output SHALL equal latched midstate whenever busy=1.
REQ-027 In ISSUE req_valid SHALL be 1 with midstate/block2 stable until req_valid&&req_ready; transfer cycle moves to WAIT; req_valid low in WAIT/IDLE.
REQ-028 At most one request SHALL be outstanding.
REQ-029 In WAIT, rsp_valid=1 SHALL increment hash_count (saturating at 32'hFFFFFFFF) and compare rsp_hash as 256-bit unsigned against target.
REQ-030 rsp_hash <= target SHALL set found=1, found_nonce=current nonce, pulse done, clear busy, go IDLE.
REQ-031 Miss with nonce==nonce_end SHALL pulse done with found=0, clear busy, go IDLE.
REQ-032 Miss otherwise SHALL increment nonce by 1 and go ISSUE; next req_valid one cycle after rsp_valid.
REQ-033 nonce_end=32'hFFFFFFFF SHALL terminate after that nonce without wrapping to 0.
REQ-034 nonce_start > nonce_end SHALL issue no request: done pulses the cycle after start, found=0, hash_count=0.
REQ-035 rsp_valid in IDLE or ISSUE SHALL be ignored.
REQ-036 abort=1 in ISSUE or WAIT SHALL go IDLE next edge, clear busy, no done pulse, found unchanged; later stray rsp_valid ignored.
REQ-037 start and abort both high in IDLE: abort wins, no job starts.

Reset
REQ-038 rst=1 SHALL immediately force IDLE, req_valid=0, busy=0, done=0, found=0, found_nonce=0, hash_count=0, midstate=0, block2=0.
REQ-039 Reset mid-job SHALL discard the job; first activity after release requires a new start.

Verification
REQ-040 Hit on 3rd nonce: midstate=256'h7f10b95b...49cc9588, tail=96'h0, nonce 5..10, target all-ones >> 8, model returns hash > target for 5,6 and 256'h0 for 7 -> found=1, found_nonce=7, hash_count=3, one done pulse.
REQ-041 No hit: nonce 0..3, target=0, nonzero hashes -> exactly 4 requests, done with found=0, hash_count=4.
REQ-042 Backpressure: req_ready low 5 cycles -> req_valid held, block2 stable, block2[96:127]=nonce_start, block2[448:511]=64'd640.
REQ-043 End of range: nonce 32'hFFFFFFFE..32'hFFFFFFFF, misses -> exactly 2 requests, no nonce 0 issued; start=9,end=3 -> done next cycle, no request.
REQ-044 Abort in WAIT then late rsp_valid with hash 0 -> busy=0, found=0, no done; rst asserted mid-ISSUE -> all outputs zero same cycle.

Source files
------------

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher
// Walks a nonce range for one mining job. Each nonce goes to the SHA-256
// wrapper as a midstate plus a padded second block. Each returned hash is
// compared against the job target. The job ends on the first hash that
// meets the target, on the last nonce of the range, or on abort.
module nonce_dispatcher (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [0:255] midstate_in,
    input  logic [0:95]  tail_in,
    input  logic [0:255] target_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         req_valid,
    input  logic         req_ready,
    output logic [0:255] midstate,
    output logic [0:511] block2,
    input  logic         rsp_valid,
    input  logic [0:255] rsp_hash,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [31:0]  hash_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // The second SHA-256 block always carries an 80-byte header, i.e. 640 bits.
    localparam logic [63:0] MSG_BITS = 64'd640;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    state_t state;
    state_t state_next;

    // Job parameters captured at launch so the inputs may change mid-job.
    logic [0:255] midstate_q;
    logic [0:95]  tail_q;
    logic [0:255] target_q;
    logic [31:0]  nonce_q;
    logic [31:0]  nonce_end_q;

    logic launch;
    logic range_empty;
    logic transfer;
    logic rsp_take;
    logic hit;
    logic last_nonce;

    // Decode the events that drive both the FSM and the datapath; abort masks everything
    always_comb begin
        launch      = (state == IDLE) && start && !abort;
        range_empty = nonce_start > nonce_end;
        transfer    = (state == ISSUE) && !abort && req_ready;
        rsp_take    = (state == WAIT) && !abort && rsp_valid;
        hit         = rsp_hash <= target_q;
        last_nonce  = nonce_q == nonce_end_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: an empty range never leaves IDLE, it only pulses done
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch && !range_empty) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (transfer) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (rsp_take) begin
                    state_next = (hit || last_nonce) ? IDLE : ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the job description on launch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            midstate_q  <= '0;
            tail_q      <= '0;
            target_q    <= '0;
            nonce_end_q <= '0;
        end else if (launch) begin
            midstate_q  <= midstate_in;
            tail_q      <= tail_in;
            target_q    <= target_in;
            nonce_end_q <= nonce_end;
        end
    end

    // Current nonce: loaded at launch, advanced only on a miss that is not the last nonce, so it never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nonce_q <= '0;
        end else if (launch) begin
            nonce_q <= nonce_start;
        end else if (rsp_take && !hit && !last_nonce) begin
            nonce_q <= nonce_q + 32'd1;
        end
    end

    // Count checked responses for the current job, saturating rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_count <= '0;
        end else if (launch) begin
            hash_count <= '0;
        end else if (rsp_take && (hash_count != COUNT_MAX)) begin
            hash_count <= hash_count + 32'd1;
        end
    end

    // Job result flags; done is a single-cycle pulse, found/found_nonce persist until the next launch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                found       <= 1'b0;
                found_nonce <= '0;
                done        <= range_empty;
            end else if (rsp_take) begin
                if (hit) begin
                    found       <= 1'b1;
                    found_nonce <= nonce_q;
                    done        <= 1'b1;
                end else if (last_nonce) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // Outputs toward the hasher; block2 is only driven while a job is live so reset leaves it all-zero
    always_comb begin
        req_valid = (state == ISSUE);
        busy      = (state != IDLE);
        midstate  = midstate_q;
        block2    = '0;
        if (busy) begin
            block2 = {tail_q, nonce_q, 1'b1, 319'd0, MSG_BITS};
        end
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher
// Directed jobs against nonce_dispatcher with a bench-side hasher and a
// job-level reference model that predicts every output each cycle.
`timescale 1ns/1ps
module tb_nonce_dispatcher;

    localparam logic [0:255] MID_A = 256'h7f10b95b_1c2d3e4f_5a6b7c8d_9eafb0c1_d2e3f405_16273849_5a6b7c8d_49cc9588;
    localparam logic [0:255] MID_B = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
    localparam logic [0:255] MID_C = 256'hdead_beef_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd;
    localparam logic [0:95]  TAIL_A = 96'h0;
    localparam logic [0:95]  TAIL_B = 96'h4d2a_1b3c_5e6f_7081_92a3_b4c5;
    localparam logic [0:95]  TAIL_C = 96'hffee_ddcc_bbaa_9988_7766_5544;
    localparam logic [0:255] TGT_SHR8 = {8'h00, {248{1'b1}}};
    localparam logic [0:255] TGT_ZERO = '0;
    localparam logic [0:255] TGT_MAX  = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [0:255] midstate_in = '0;
    logic [0:95]  tail_in = '0;
    logic [0:255] target_in = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         req_valid;
    logic         req_ready = 1'b1;
    logic [0:255] midstate;
    logic [0:511] block2;
    logic         rsp_valid = 1'b0;
    logic [0:255] rsp_hash = '0;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [31:0]  hash_count;

    // Hasher configuration, owned by the stimulus process
    logic         hit_en = 1'b0;
    logic [31:0]  hit_n = '0;
    int           rsp_lat = 1;
    int           stall_len = 0;

    // Literal expectations for the current job, owned by the stimulus process
    logic         lit_valid = 1'b0;
    logic         lit_found = 1'b0;
    logic [31:0]  lit_fn = '0;
    logic [31:0]  lit_count = '0;
    int           lit_reqs = 0;
    logic [31:0]  lit_first = '0;

    // Reference model, owned by the compare process
    logic         m_active = 1'b0;
    logic         m_out = 1'b0;
    logic         m_done_due = 1'b0;
    logic         m_found = 1'b0;
    logic [31:0]  m_fn = '0;
    logic [31:0]  m_count = '0;
    logic [31:0]  m_cur = '0;
    logic [31:0]  m_ne = '0;
    logic [0:255] m_mid = '0;
    logic [0:95]  m_tail = '0;
    logic [0:255] m_target = '0;
    logic [31:0]  m_q[$];
    int           m_age = 0;
    int           obs_reqs = 0;
    logic         prev_stall = 1'b0;
    logic [0:511] prev_block2 = '0;

    int vectors = 0;
    int miscompares = 0;

    nonce_dispatcher dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .midstate_in (midstate_in),
        .tail_in     (tail_in),
        .target_in   (target_in),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .midstate    (midstate),
        .block2      (block2),
        .rsp_valid   (rsp_valid),
        .rsp_hash    (rsp_hash),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .found_nonce (found_nonce),
        .hash_count  (hash_count)
    );

    always #10 clk = ~clk;

    // Pretend hash: zero for the chosen winning nonce, otherwise a large nonzero value
    function automatic logic [0:255] tb_hash(input logic [31:0] n);
        if (hit_en && (n == hit_n)) begin
            return '0;
        end
        return {8'hFF, 216'h0, n};
    endfunction

    task automatic check_output(input string name, input logic [511:0] actual, input logic [511:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Hasher stand-in: optional backpressure on the first request, then a response rsp_lat cycles after transfer
    int          stall_cnt = 0;
    int          rsp_wait = 0;
    logic [31:0] rsp_nonce = '0;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            rsp_valid = 1'b0;
            rsp_wait  = 0;
            stall_cnt = 0;
            req_ready = 1'b1;
        end else begin
            rsp_valid = 1'b0;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    rsp_valid = 1'b1;
                    rsp_hash  = tb_hash(rsp_nonce);
                end
            end
            if (start) begin
                stall_cnt = stall_len;
            end
            if (req_valid && (stall_cnt > 0)) begin
                req_ready = 1'b0;
                stall_cnt--;
            end else begin
                req_ready = 1'b1;
            end
            if (req_valid && req_ready) begin
                rsp_nonce = block2[96:127];
                rsp_wait  = rsp_lat;
            end
        end
    end

    // Compare the DUT against the job model every cycle, then advance the model on this cycle's inputs
    always @(negedge clk) begin
        logic [31:0]  head;
        logic [0:511] exp_b2;
        #2;
        if (rst) begin
            check_output("rst_req_valid", req_valid, 1'b0);
            check_output("rst_busy", busy, 1'b0);
            check_output("rst_done", done, 1'b0);
            check_output("rst_found", found, 1'b0);
            check_output("rst_found_nonce", found_nonce, 32'h0);
            check_output("rst_hash_count", hash_count, 32'h0);
            check_output("rst_midstate", midstate, 256'h0);
            check_output("rst_block2", block2, 512'h0);
            m_active   = 1'b0;
            m_out      = 1'b0;
            m_done_due = 1'b0;
            m_found    = 1'b0;
            m_fn       = '0;
            m_count    = '0;
            m_mid      = '0;
            m_tail     = '0;
            m_q.delete();
            prev_stall = 1'b0;
            obs_reqs   = 0;
        end else begin
            head   = (m_q.size() > 0) ? m_q[0] : 32'h0;
            exp_b2 = m_active ? {m_tail, (m_out ? m_cur : head), 1'b1, 319'd0, 64'd640} : 512'h0;
            check_output("busy", busy, m_active);
            check_output("req_valid", req_valid, m_active && !m_out);
            check_output("done", done, m_done_due);
            check_output("found", found, m_found);
            check_output("found_nonce", found_nonce, m_fn);
            check_output("hash_count", hash_count, m_count);
            check_output("midstate", midstate, m_mid);
            check_output("block2", block2, exp_b2);
            if (prev_stall) begin
                check_output("block2_stable", block2, prev_block2);
            end
            if (lit_valid && m_active && !m_out && (obs_reqs == 0)) begin
                check_output("lit_first_nonce", block2[96:127], lit_first);
                check_output("lit_length", block2[448:511], 64'd640);
            end
            if (lit_valid && m_done_due) begin
                check_output("lit_found", found, lit_found);
                check_output("lit_found_nonce", found_nonce, lit_fn);
                check_output("lit_hash_count", hash_count, lit_count);
                check_output("lit_requests", obs_reqs, lit_reqs);
            end
            prev_stall  = req_valid && !req_ready;
            prev_block2 = block2;
            if (req_valid && req_ready) begin
                obs_reqs++;
            end

            m_done_due = 1'b0;
            if (!m_active) begin
                if (start && !abort) begin
                    m_mid    = midstate_in;
                    m_tail   = tail_in;
                    m_target = target_in;
                    m_ne     = nonce_end;
                    m_found  = 1'b0;
                    m_fn     = '0;
                    m_count  = '0;
                    m_out    = 1'b0;
                    m_age    = 0;
                    obs_reqs = 0;
                    m_q.delete();
                    if (nonce_start > nonce_end) begin
                        m_done_due = 1'b1;
                    end else begin
                        for (logic [32:0] n = {1'b0, nonce_start};
                             (n <= {1'b0, nonce_end}) && (m_q.size() < 4096); n++) begin
                            m_q.push_back(n[31:0]);
                            if (tb_hash(n[31:0]) <= target_in) begin
                                break;
                            end
                        end
                        m_active = 1'b1;
                    end
                end
            end else if (abort) begin
                m_active = 1'b0;
                m_out    = 1'b0;
                m_q.delete();
            end else begin
                if (m_out && rsp_valid) begin
                    if (m_count != 32'hFFFF_FFFF) begin
                        m_count = m_count + 32'd1;
                    end
                    if (tb_hash(m_cur) <= m_target) begin
                        m_found    = 1'b1;
                        m_fn       = m_cur;
                        m_done_due = 1'b1;
                        m_active   = 1'b0;
                    end else if (m_cur == m_ne) begin
                        m_done_due = 1'b1;
                        m_active   = 1'b0;
                    end
                    m_out = 1'b0;
                end else if (!m_out && req_ready && (m_q.size() > 0)) begin
                    m_cur = m_q.pop_front();
                    m_out = 1'b1;
                end
                m_age++;
                if (m_age > 500) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL watchdog: job still busy after %0d cycles, required to finish", m_age);
                    m_active = 1'b0;
                    m_out    = 1'b0;
                    m_q.delete();
                end
            end
        end
    end

    // Configure the hasher and literal expectations, then pulse start for one cycle
    task automatic apply_stimulus(input logic [0:255] mid, input logic [0:95] tail, input logic [0:255] tgt,
                                  input logic [31:0] ns, input logic [31:0] ne,
                                  input logic hen, input logic [31:0] hn,
                                  input logic lv, input logic lf, input logic [31:0] lfn,
                                  input logic [31:0] lc, input int lr);
        @(negedge clk);
        midstate_in = mid;
        tail_in     = tail;
        target_in   = tgt;
        nonce_start = ns;
        nonce_end   = ne;
        hit_en      = hen;
        hit_n       = hn;
        lit_valid   = lv;
        lit_found   = lf;
        lit_fn      = lfn;
        lit_count   = lc;
        lit_reqs    = lr;
        lit_first   = ns;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_job_end();
        int n = 0;
        while ((m_active || m_done_due) && (n < 600)) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] hit on third nonce");
        rsp_lat = 2;
        apply_stimulus(MID_A, TAIL_A, TGT_SHR8, 32'd5, 32'd10, 1'b1, 32'd7, 1'b1, 1'b1, 32'd7, 32'd3, 3);
        wait_job_end();

        $display("[TB] no hit, start while busy ignored");
        rsp_lat = 3;
        apply_stimulus(MID_B, TAIL_B, TGT_ZERO, 32'd0, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd4, 4);
        repeat (2) @(negedge clk);
        nonce_start = 32'd100;
        nonce_end   = 32'd200;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_job_end();

        $display("[TB] backpressure, hash equal to target");
        stall_len = 5;
        rsp_lat   = 1;
        apply_stimulus(MID_C, TAIL_C, TGT_ZERO, 32'd40, 32'd41, 1'b1, 32'd41, 1'b1, 1'b1, 32'd41, 32'd2, 2);
        wait_job_end();
        stall_len = 0;

        $display("[TB] start and abort together in idle");
        @(negedge clk);
        nonce_start = 32'd1;
        nonce_end   = 32'd2;
        start       = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] empty range");
        apply_stimulus(MID_B, TAIL_C, TGT_MAX, 32'd9, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 0);
        wait_job_end();

        $display("[TB] top of nonce space");
        apply_stimulus(MID_A, TAIL_B, TGT_ZERO, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0,
                       1'b1, 1'b0, 32'd0, 32'd2, 2);
        wait_job_end();

        $display("[TB] abort while waiting, late winning response");
        rsp_lat = 6;
        apply_stimulus(MID_C, TAIL_A, TGT_ZERO, 32'd20, 32'd30, 1'b1, 32'd20, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] reset during issue");
        stall_len = 20;
        rsp_lat   = 1;
        apply_stimulus(MID_A, TAIL_A, TGT_SHR8, 32'd70, 32'd80, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        stall_len = 0;
        repeat (2) @(negedge clk);

        $display("[TB] recovery job, hit on first nonce");
        apply_stimulus(MID_B, TAIL_A, TGT_ZERO, 32'd50, 32'd60, 1'b1, 32'd50, 1'b1, 1'b1, 32'd50, 32'd1, 1);
        wait_job_end();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
